ahb_slave_mux: RTL and testbench
================================

Name: ahb_slave_mux

Overview:
- Data-phase response multiplexer, directly downstream of the AHB address decoder.
- Registers the decoder's one-hot address-phase slave select on each accepted transfer, then routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master.
- Contains a built-in default slave that answers unmapped NONSEQ/SEQ transfers with the two-cycle AHB ERROR response.
- Its ahb_hready_out is the bus HREADY: it feeds the master, every slave, and the decoder's multi_ready_in.

Parameters:
- SLAVE_DEVICES, 4, number of slaves; range 1..8.
- AHB_DATA_WIDTH, 32, HRDATA width.
- TIMEOUT_CYCLES, 16, wait-state limit; used only with the optional feature; minimum 2.

Ports:
- ahb_clk_in  input  1  bus clock.
- ahb_rstn_in  input  1  asynchronous active-low reset.
- ahb_htrans_in  input  2  master HTRANS, address phase (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- slave_sel_in  input  SLAVE_DEVICES  one-hot address-phase select from the decoder.
- slave_hrdata_in  input  SLAVE_DEVICES*AHB_DATA_WIDTH  concatenated slave read data; slave i occupies bits [i*W +: W].
- slave_hreadyout_in  input  SLAVE_DEVICES  per-slave HREADYOUT.
- slave_hresp_in  input  SLAVE_DEVICES  per-slave HRESP (1 = ERROR).
- ahb_hrdata_out  output  AHB_DATA_WIDTH  read data to the master.
- ahb_hready_out  output  1  bus HREADY.
- ahb_hresp_out  output  1  HRESP to the master.
- data_sel_out  output  SLAVE_DEVICES  registered data-phase select.

Behaviour:
- Clock and reset: one clock, ahb_clk_in. Reset ahb_rstn_in is asynchronous and active-low.
- Reset values: state IDLE, data_sel_out = 0, ahb_hready_out = 1, ahb_hresp_out = 0, ahb_hrdata_out = 0.
- Transfer acceptance: a transfer is accepted only on a rising edge where ahb_hready_out = 1. Otherwise the state and data_sel_out hold.
- Next state when a transfer is accepted:
  - htrans is IDLE or BUSY -> IDLE.
  - htrans is NONSEQ/SEQ and slave_sel_in has exactly one bit set -> SLAVE, data_sel_out <= slave_sel_in.
  - htrans is NONSEQ/SEQ and slave_sel_in is zero or has more than one bit set -> ERR1, data_sel_out <= 0.
- State outputs:
  - IDLE: hready = 1, hresp = 0, hrdata = 0.
  - SLAVE: hready, hresp and hrdata are combinational copies of the selected slave's signals (zero added latency). The state is left only on an edge where that slave's hreadyout = 1, and the next state then follows the acceptance rules above. A slave ERROR is passed through untouched; the slave owns its own two-cycle sequence.
  - ERR1: hready = 0, hresp = 1, hrdata = 0. Always -> ERR2 on the next edge.
  - ERR2: hready = 1, hresp = 1, hrdata = 0. This is an acceptance edge, so the next state follows the acceptance rules.
- Back-to-back transfers: pipelined with zero bubble, so a new address phase is accepted in the same cycle as the previous data phase completes.
- Select stability: data_sel_out changes only on acceptance edges. slave_sel_in glitches during wait states have no effect.
- SLAVE_DEVICES = 1: an all-zero select is treated as unmapped.
- Reset mid-transfer: the block returns to IDLE immediately. Any in-flight slave response is ignored.

Optional Feature:
- Macro: AHB_SLAVE_MUX_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to SLAVE and increments on each SLAVE cycle with the selected hreadyout = 0.
  - When the count reaches TIMEOUT_CYCLES-1 and hreadyout is still 0, the state goes to ERR1 and data_sel_out clears. The master then sees the standard two-cycle ERROR.
  - A late hreadyout from the abandoned slave is ignored.
  - An extra output port timeout_out (1 bit, reset 0) pulses high for the single cycle in which the abort edge occurs.
- When undefined: no counter, no timeout_out port, and a slave may stall the bus indefinitely.

Decomposition:
- Shared package/include ahb_pkg holds:
  - HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY/HRESP_ERROR.
  - The mux state encoding (MUX_IDLE, MUX_SLAVE, MUX_ERR1, MUX_ERR2).
  - These are shared with the decoder and future slaves.
- One sub-module: ahb_default_slave, holding the ERR1/ERR2 sequencing and producing hready/hresp for unmapped transfers. The top handles select registering, the datapath mux and the timeout.

Test Plan:
1. Reset, then NONSEQ with slave_sel_in = 4'b0010, and slave1 returns hreadyout = 1, hrdata = 32'hA5A5_0001 -> the next cycle shows ahb_hrdata_out = 32'hA5A5_0001, hready = 1, hresp = 0, data_sel_out = 4'b0010.
2. NONSEQ to slave2; slave2 holds hreadyout = 0 for 3 cycles, while slave_sel_in toggles to 4'b0001 meanwhile -> hready is low for exactly 3 cycles, data_sel_out stays at 4'b0100, and data is taken from slave2.
3. NONSEQ with slave_sel_in = 0 -> ERR1 (hready = 0, hresp = 1), then ERR2 (hready = 1, hresp = 1), then a following SEQ to slave0 completes OKAY.
4. Back-to-back NONSEQ to slave0 then slave3, all zero-wait -> consecutive data phases with no bubble, data_sel_out goes 0001 then 1000. IDLE with slave_sel_in = 0 -> OKAY, no error.
5. Drive ahb_rstn_in low while slave1 is stalled -> outputs are at reset values asynchronously, and the first transfer after reset behaves as in test 1.
6. With AHB_SLAVE_MUX_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave0 stalls forever -> timeout_out pulses once after 16 wait cycles, then the ERROR pair follows and the bus accepts the next transfer.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings for the decoder, the response mux and slaves.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase state of the response mux.
  typedef enum logic [1:0] {
    MUX_IDLE  = 2'd0,
    MUX_SLAVE = 2'd1,
    MUX_ERR1  = 2'd2,
    MUX_ERR2  = 2'd3
  } mux_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped transfers with the two-cycle AHB ERROR response.
// Latency: ERR1 the cycle after err_start_i, ERR2 the cycle after that.
// Backpressure: holds hready low during ERR1; ERR2 is an acceptance cycle.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic err_start_i,
  output logic busy_o,
  output logic hready_o,
  output logic hresp_o
);

  mux_state_e state_q, state_d;

  // State register; only IDLE, ERR1 and ERR2 are ever used here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= MUX_IDLE;
    else          state_q <= state_d;
  end

  // Next state and response outputs of the error sequence.
  always_comb begin
    state_d  = state_q;
    busy_o   = 1'b0;
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    case (state_q)
      MUX_ERR1: begin
        busy_o   = 1'b1;
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
        state_d  = MUX_ERR2;
      end
      MUX_ERR2: begin
        busy_o   = 1'b1;
        hresp_o  = HRESP_ERROR;
        // ERR2 completes with hready high, so a new unmapped transfer may start here.
        state_d  = err_start_i ? MUX_ERR1 : MUX_IDLE;
      end
      default: begin
        state_d  = err_start_i ? MUX_ERR1 : MUX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB data-phase response mux with built-in default slave; optional wait timeout (AHB_SLAVE_MUX_TIMEOUT_EN).
// Latency: zero-cycle combinational return of the selected slave's response; select registered on acceptance.
// Backpressure: bus HREADY follows the selected slave (or default slave); selection holds while HREADY is low.
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int SLAVE_DEVICES  = 4,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                    ahb_clk_in,
  input  logic                                    ahb_rstn_in,
  input  logic [1:0]                              ahb_htrans_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_sel_in,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_hrdata_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_hreadyout_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_hresp_in,
  output logic [AHB_DATA_WIDTH-1:0]               ahb_hrdata_out,
  output logic                                    ahb_hready_out,
  output logic                                    ahb_hresp_out,
  output logic [SLAVE_DEVICES-1:0]                data_sel_out
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
  ,output logic                                   timeout_out
`endif
);

  logic [SLAVE_DEVICES-1:0]  sel_q, sel_d;
  logic                      sel_rdy, sel_resp;
  logic [AHB_DATA_WIDTH-1:0] sel_data;
  logic                      slave_active, xfer_active, sel_onehot;
  logic                      accept, abort, err_start;
  logic                      err_busy, err_hready, err_hresp;

  assign slave_active = |sel_q;
  assign xfer_active  = (ahb_htrans_in == HTRANS_NONSEQ) || (ahb_htrans_in == HTRANS_SEQ);
  // Zero or multi-hot selects are unmapped and go to the default slave.
  assign sel_onehot   = (slave_sel_in != '0) &&
                        ((slave_sel_in & (slave_sel_in - 1'b1)) == '0);

  // AND-OR mux of the registered one-hot select; all zero when no slave owns the data phase.
  always_comb begin
    sel_rdy  = 1'b0;
    sel_resp = 1'b0;
    sel_data = '0;
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (sel_q[i]) begin
        sel_rdy  = sel_rdy  | slave_hreadyout_in[i];
        sel_resp = sel_resp | slave_hresp_in[i];
        sel_data = sel_data | slave_hrdata_in[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
      end
    end
  end

  assign ahb_hready_out = err_busy ? err_hready : (slave_active ? sel_rdy : 1'b1);
  assign ahb_hresp_out  = err_busy ? err_hresp  : (slave_active ? sel_resp : HRESP_OKAY);
  assign ahb_hrdata_out = sel_data;
  assign data_sel_out   = sel_q;
  assign accept         = ahb_hready_out;
  assign err_start      = abort | (accept & xfer_active & ~sel_onehot);

`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign abort       = slave_active & ~sel_rdy & (wait_cnt_q == CNT_LAST);
  assign timeout_out = abort;

  // Wait counter: cleared on every acceptance (covers entry to SLAVE), counts stalled SLAVE cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept || abort)                wait_cnt_d = '0;
    else if (slave_active && !sel_rdy)  wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) wait_cnt_q <= '0;
    else              wait_cnt_q <= wait_cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  // Select capture: only on acceptance edges; an abort drops the stalled slave.
  always_comb begin
    sel_d = sel_q;
    if (abort)       sel_d = '0;
    else if (accept) sel_d = (xfer_active && sel_onehot) ? slave_sel_in : '0;
  end

  // Registered data-phase select.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) sel_q <= '0;
    else              sel_q <= sel_d;
  end

  ahb_default_slave u_default_slave (
    .clk_i       (ahb_clk_in),
    .rst_n_i     (ahb_rstn_in),
    .err_start_i (err_start),
    .busy_o      (err_busy),
    .hready_o    (err_hready),
    .hresp_o     (err_hresp)
  );

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Self-checking bench for ahb_slave_mux: directed steps plus random traffic vs a transaction-level model.
// Latency: checks outputs mid-cycle against the model each cycle.
// Backpressure: random slave wait states; optional timeout exercised when AHB_SLAVE_MUX_TIMEOUT_EN is defined.
module tb_ahb_slave_mux;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [1:0]     htrans;
  logic [N-1:0]   sel;
  logic [N*W-1:0] hrdata;
  logic [N-1:0]   hrdyo;
  logic [N-1:0]   hresp;
  logic [W-1:0]   o_data;
  logic           o_rdy;
  logic           o_resp;
  logic [N-1:0]   o_sel;
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
  logic           o_tmo;
`endif

  ahb_slave_mux #(.SLAVE_DEVICES(N), .AHB_DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .ahb_clk_in         (clk),
    .ahb_rstn_in        (rstn),
    .ahb_htrans_in      (htrans),
    .slave_sel_in       (sel),
    .slave_hrdata_in    (hrdata),
    .slave_hreadyout_in (hrdyo),
    .slave_hresp_in     (hresp),
    .ahb_hrdata_out     (o_data),
    .ahb_hready_out     (o_rdy),
    .ahb_hresp_out      (o_resp),
    .data_sel_out       (o_sel)
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
    ,.timeout_out       (o_tmo)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: what owns the current data phase. 0 none, 1 slave m_idx, 2 error first cycle, 3 error second cycle.
  int m_kind = 0;
  int m_idx  = 0;
  int m_wait = 0;

  logic [W-1:0] e_data;
  logic         e_rdy, e_resp, e_tmo;
  logic [N-1:0] e_sel;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    e_data = '0; e_rdy = 1'b1; e_resp = 1'b0; e_sel = '0; e_tmo = 1'b0;
    case (m_kind)
      1: begin
        e_sel[m_idx] = 1'b1;
        e_rdy  = hrdyo[m_idx];
        e_resp = hresp[m_idx];
        e_data = hrdata[m_idx*W +: W];
        e_tmo  = (!hrdyo[m_idx] && m_wait == TO-1);
      end
      2: begin e_rdy = 1'b0; e_resp = 1'b1; end
      3: begin e_rdy = 1'b1; e_resp = 1'b1; end
      default: ;
    endcase
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    model_outputs();
    if (m_kind == 2) begin
      m_kind = 3;
    end else if (e_rdy) begin
      if (htrans >= 2) begin
        if ($countones(sel) == 1) begin
          m_kind = 1;
          m_wait = 0;
          for (int i = 0; i < N; i++) if (sel[i]) m_idx = i;
        end else begin
          m_kind = 2;
        end
      end else begin
        m_kind = 0;
      end
    end else if (m_kind == 1) begin
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
      if (m_wait == TO-1) m_kind = 2;
      else m_wait++;
`endif
    end
  endtask

  task automatic at_neg(input string ph);
    @(negedge clk);
    model_outputs();
    check({ph, "_data"}, o_data, e_data);
    check({ph, "_rdy"},  W'(o_rdy),  W'(e_rdy));
    check({ph, "_resp"}, W'(o_resp), W'(e_resp));
    check({ph, "_sel"},  W'(o_sel),  W'(e_sel));
`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
    check({ph, "_tmo"},  W'(o_tmo),  W'(e_tmo));
`endif
  endtask

  task automatic edge_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slave(input int i, input logic r, input logic [W-1:0] d, input logic e);
    hrdyo[i] = r;
    hrdata[i*W +: W] = d;
    hresp[i] = e;
  endtask

  task automatic check_reset_vals(input string ph);
    check({ph, "_data"}, o_data, '0);
    check({ph, "_rdy"},  W'(o_rdy),  W'(1));
    check({ph, "_resp"}, W'(o_resp), W'(0));
    check({ph, "_sel"},  W'(o_sel),  W'(0));
  endtask

  // Single zero-wait NONSEQ to slave1 with known data.
  task automatic t1_seq(input string ph);
    htrans = 2'd2; sel = 4'b0010;
    set_slave(1, 1'b1, 32'hA5A5_0001, 1'b0);
    at_neg({ph, "_addr"});
    edge_step();
    htrans = 2'd0; sel = 4'b0000;
    at_neg({ph, "_dph"});
    check({ph, "_hrdata"}, o_data, 32'hA5A5_0001);
    check({ph, "_hready"}, W'(o_rdy), W'(1));
    check({ph, "_hresp"},  W'(o_resp), W'(0));
    check({ph, "_dsel"},   W'(o_sel), W'(4'b0010));
    edge_step();
  endtask

  initial begin
    rstn = 1'b0; htrans = 2'd0; sel = '0; hrdata = '0; hrdyo = '1; hresp = '0;
    #12;
    check_reset_vals("reset");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Test 1
    t1_seq("t1");

    // Test 2: slave2 stalls 3 cycles while the address-phase select glitches.
    htrans = 2'd2; sel = 4'b0100;
    set_slave(2, 1'b1, 32'h0, 1'b0);
    at_neg("t2_addr");
    edge_step();
    hrdyo[2] = 1'b0; hrdata[2*W +: W] = 32'hB0B0_0002;
    for (int k = 0; k < 3; k++) begin
      sel = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      at_neg("t2_wait");
      check("t2_wait_hready", W'(o_rdy), W'(0));
      check("t2_wait_dsel",   W'(o_sel), W'(4'b0100));
      edge_step();
    end
    hrdyo[2] = 1'b1; htrans = 2'd0; sel = '0;
    at_neg("t2_done");
    check("t2_done_hready", W'(o_rdy), W'(1));
    check("t2_done_hrdata", o_data, 32'hB0B0_0002);
    check("t2_done_dsel",   W'(o_sel), W'(4'b0100));
    edge_step();

    // Test 3: unmapped NONSEQ, then SEQ to slave0.
    htrans = 2'd2; sel = 4'b0000;
    at_neg("t3_addr");
    edge_step();
    htrans = 2'd3; sel = 4'b0001;
    set_slave(0, 1'b1, 32'hC0C0_0000, 1'b0);
    at_neg("t3_err1");
    check("t3_err1_hready", W'(o_rdy), W'(0));
    check("t3_err1_hresp",  W'(o_resp), W'(1));
    edge_step();
    at_neg("t3_err2");
    check("t3_err2_hready", W'(o_rdy), W'(1));
    check("t3_err2_hresp",  W'(o_resp), W'(1));
    edge_step();
    htrans = 2'd0; sel = '0;
    at_neg("t3_seq");
    check("t3_seq_hresp", W'(o_resp), W'(0));
    check("t3_seq_dsel",  W'(o_sel), W'(4'b0001));
    check("t3_seq_data",  o_data, 32'hC0C0_0000);
    edge_step();

    // Test 4: back-to-back slave0, slave3, then IDLE.
    set_slave(3, 1'b1, 32'hD0D0_0003, 1'b0);
    htrans = 2'd2; sel = 4'b0001;
    at_neg("t4_a");
    edge_step();
    htrans = 2'd2; sel = 4'b1000;
    at_neg("t4_b");
    check("t4_b_dsel", W'(o_sel), W'(4'b0001));
    edge_step();
    htrans = 2'd0; sel = 4'b0000;
    at_neg("t4_c");
    check("t4_c_dsel",  W'(o_sel), W'(4'b1000));
    check("t4_c_data",  o_data, 32'hD0D0_0003);
    edge_step();
    at_neg("t4_d");
    check("t4_d_hresp", W'(o_resp), W'(0));
    check("t4_d_dsel",  W'(o_sel), W'(0));
    edge_step();

    // Test 5: asynchronous reset while slave1 stalls.
    htrans = 2'd2; sel = 4'b0010;
    set_slave(1, 1'b1, 32'h1111_1111, 1'b0);
    at_neg("t5_addr");
    edge_step();
    hrdyo[1] = 1'b0; htrans = 2'd0; sel = '0;
    at_neg("t5_stall");
    edge_step();
    #2 rstn = 1'b0;
    #1 check_reset_vals("t5_rst");
    m_kind = 0;
    hrdyo[1] = 1'b1;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    t1_seq("t5_after");

`ifdef AHB_SLAVE_MUX_TIMEOUT_EN
    // Test 6: slave0 stalls forever, timeout aborts it.
    begin
      int pulses = 0;
      int pulse_at = -1;
      htrans = 2'd2; sel = 4'b0001;
      set_slave(0, 1'b1, 32'h0, 1'b0);
      at_neg("t6_addr");
      edge_step();
      hrdyo[0] = 1'b0; htrans = 2'd0; sel = '0;
      for (int k = 0; k < 24; k++) begin
        at_neg("t6_run");
        if (o_tmo === 1'b1) begin
          pulses++;
          if (pulse_at < 0) pulse_at = k;
        end
        if (k == 20) hrdyo[0] = 1'b1;
        edge_step();
      end
      check("t6_pulses",   W'(pulses),   W'(1));
      check("t6_pulse_at", W'(pulse_at), W'(15));
      htrans = 2'd2; sel = 4'b1000;
      at_neg("t6_next");
      edge_step();
      htrans = 2'd0; sel = '0;
      at_neg("t6_next_dph");
      check("t6_next_dsel", W'(o_sel), W'(4'b1000));
      edge_step();
    end
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      int r;
      htrans = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 6)      sel = N'(1 << $urandom_range(0, N-1));
      else if (r < 8) sel = '0;
      else            sel = N'($urandom);
      for (int i = 0; i < N; i++) begin
        hrdyo[i] = ($urandom_range(0, 3) != 0);
        hresp[i] = ($urandom_range(0, 7) == 0);
        hrdata[i*W +: W] = $urandom;
      end
      at_neg("rnd");
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
